// File: rtl/dyn_bias_seq.sv
// rtl/dyn_bias_seq.sv - OTA dynamic-bias gain-code sequencer with soft ramp and over-current back-off
module dyn_bias_seq #(
  parameter int CODE_W     = 6,
  parameter int STEP_CYC   = 16,
  parameter int SETTLE_CYC = 8,
  parameter int OC_MAX     = 3
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          en,
  input  logic [CODE_W-1:0]             tgt_code,
  input  logic                          tgt_vld,
  output logic                          tgt_rdy,
  input  logic                          oc_flag,
  input  logic                          clr_fault,
  output logic [CODE_W-1:0]             gain_code,
  output logic                          bias_en,
  output logic                          ready,
  output logic                          fault,
  output logic [$clog2(OC_MAX+1)-1:0]   oc_cnt
);

  localparam int OCW = $clog2(OC_MAX + 1);
  localparam int STW = $clog2(STEP_CYC + 1);
  localparam int SEW = $clog2(SETTLE_CYC + 1);
  localparam logic [OCW-1:0]    OC_LIM     = OCW'(OC_MAX);
  localparam logic [STW-1:0]    STEP_LIM   = STW'(STEP_CYC);
  localparam logic [SEW-1:0]    SETTLE_LIM = SEW'(SETTLE_CYC);
  localparam logic [CODE_W-1:0] CODE_MAX   = '1;

  typedef enum logic [2:0] {S_OFF, S_RAMP, S_SETTLE, S_HOLD, S_FAULT} state_t;

  state_t            state_q, state_d;
  logic [CODE_W-1:0] tgt_q, tgt_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              bias_en_q, bias_en_d;
  logic              ready_q, ready_d;
  logic              fault_q, fault_d;
  logic [OCW-1:0]    oc_cnt_q, oc_cnt_d;
  logic [STW-1:0]    step_q, step_d;
  logic [SEW-1:0]    settle_q, settle_d;
  logic              oc_s1_q, oc_s2_q, oc_s3_q;

  logic              oc_rise;
  logic              accept;
  logic [CODE_W-1:0] tgt_acc;
  logic [CODE_W-1:0] eff_tgt;
  logic [CODE_W-1:0] code_dn;
  logic [CODE_W-1:0] code_up;
  logic [OCW-1:0]    oc_inc;
  logic [STW-1:0]    step_inc;
  logic [SEW-1:0]    settle_inc;
  logic              oc_hit;

  // Two-flop synchronizer for the comparator flag plus one delay stage for edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      oc_s1_q <= 1'b0;
      oc_s2_q <= 1'b0;
      oc_s3_q <= 1'b0;
    end else begin
      oc_s1_q <= oc_flag;
      oc_s2_q <= oc_s1_q;
      oc_s3_q <= oc_s2_q;
    end
  end

  // Request handshake and arithmetic helpers shared by every state
  always_comb begin
    oc_rise    = oc_s2_q & ~oc_s3_q;
    tgt_rdy    = ((state_q == S_OFF) || (state_q == S_HOLD)) && !oc_rise;
    accept     = tgt_vld & tgt_rdy;
    tgt_acc    = accept ? tgt_code : tgt_q;
    eff_tgt    = en ? tgt_q : '0;
    code_dn    = (code_q == '0) ? '0 : code_q - 1'b1;
    code_up    = (code_q == CODE_MAX) ? CODE_MAX : code_q + 1'b1;
    oc_inc     = oc_cnt_q + 1'b1;
    step_inc   = step_q + 1'b1;
    settle_inc = settle_q + 1'b1;
    oc_hit     = oc_rise && ((state_q == S_RAMP) || (state_q == S_SETTLE) || (state_q == S_HOLD));
  end

  // Next-state logic; an over-current edge overrides stepping, settling and new targets
  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_acc;
    code_d   = code_q;
    oc_cnt_d = oc_cnt_q;
    step_d   = step_q;
    settle_d = settle_q;
    if (oc_hit) begin
      code_d   = code_dn;
      tgt_d    = code_dn;
      oc_cnt_d = oc_inc;
      step_d   = '0;
      settle_d = '0;
      if (oc_inc == OC_LIM) begin
        state_d = S_FAULT;
        code_d  = '0;
      end else begin
        state_d = S_RAMP;
      end
    end else begin
      unique case (state_q)
        S_OFF: begin
          code_d = '0;
          if (en && (tgt_acc != '0)) begin
            state_d = S_RAMP;
            step_d  = '0;
          end
        end
        S_RAMP: begin
          if (code_q == eff_tgt) begin
            step_d   = '0;
            settle_d = '0;
            state_d  = (eff_tgt == '0) ? S_OFF : S_SETTLE;
          end else if (step_inc == STEP_LIM) begin
            step_d = '0;
            code_d = (code_q < eff_tgt) ? code_up : code_dn;
          end else begin
            step_d = step_inc;
          end
        end
        S_SETTLE: begin
          if (eff_tgt != code_q) begin
            state_d  = S_RAMP;
            step_d   = '0;
            settle_d = '0;
          end else if (settle_inc == SETTLE_LIM) begin
            state_d  = S_HOLD;
            settle_d = '0;
          end else begin
            settle_d = settle_inc;
          end
        end
        S_HOLD: begin
          if (!en || (accept && (tgt_code != code_q))) begin
            state_d = S_RAMP;
            step_d  = '0;
          end
        end
        S_FAULT: begin
          code_d = '0;
          if (clr_fault && !en) begin
            state_d  = S_OFF;
            oc_cnt_d = '0;
            tgt_d    = '0;
          end
        end
        default: begin
          state_d = S_OFF;
          code_d  = '0;
        end
      endcase
    end
    bias_en_d = (state_d == S_RAMP) || (state_d == S_SETTLE) || (state_d == S_HOLD);
    ready_d   = (state_d == S_HOLD);
    fault_d   = (state_d == S_FAULT);
  end

  // State and registered outputs; reset drops the bias immediately with no ramp down
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_OFF;
      tgt_q     <= '0;
      code_q    <= '0;
      bias_en_q <= 1'b0;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
      oc_cnt_q  <= '0;
      step_q    <= '0;
      settle_q  <= '0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      code_q    <= code_d;
      bias_en_q <= bias_en_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
      oc_cnt_q  <= oc_cnt_d;
      step_q    <= step_d;
      settle_q  <= settle_d;
    end
  end

  assign gain_code = code_q;
  assign bias_en   = bias_en_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign oc_cnt    = oc_cnt_q;

endmodule

// File: tb/tb_dyn_bias_seq.sv
// tb/tb_dyn_bias_seq.sv - self-checking bench for dyn_bias_seq against a closed-form ramp model
module tb_dyn_bias_seq;

  localparam int STEP   = 4;
  localparam int SETTLE = 2;
  localparam int OCMAX  = 3;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en;
  logic [5:0] tgt_code;
  logic       tgt_vld;
  logic       tgt_rdy;
  logic       oc_flag;
  logic       clr_fault;
  logic [5:0] gain_code;
  logic       bias_en;
  logic       ready;
  logic       fault;
  logic [1:0] oc_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int mcode    = 0;
  int moc      = 0;

  dyn_bias_seq #(
    .CODE_W(6), .STEP_CYC(STEP), .SETTLE_CYC(SETTLE), .OC_MAX(OCMAX)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en), .tgt_code(tgt_code), .tgt_vld(tgt_vld),
    .tgt_rdy(tgt_rdy), .oc_flag(oc_flag), .clr_fault(clr_fault),
    .gain_code(gain_code), .bias_en(bias_en), .ready(ready), .fault(fault), .oc_cnt(oc_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Move from code s toward t one LSB per STEP cycles; m counts clocks after the trigger edge.
  task automatic episode(input string tag, input int s, input int t, input bit stay);
    int d, dir, n, mv, e_code, e_rdy, e_ben, e_trdy;
    d   = (s > t) ? s - t : t - s;
    dir = (t > s) ? 1 : -1;
    n   = STEP * d + SETTLE + 4;
    for (int m = 1; m <= n; m++) begin
      @(negedge clk);
      mv = (m - 1) / STEP;
      if (mv > d) mv = d;
      e_code = s + dir * mv;
      if (stay) e_rdy = 1;
      else      e_rdy = (t != 0 && m >= STEP * d + 2 + SETTLE) ? 1 : 0;
      e_ben  = (t != 0 || m < STEP * d + 2) ? 1 : 0;
      e_trdy = (t != 0) ? e_rdy : ((m >= STEP * d + 2) ? 1 : 0);
      chk({tag, "_code"},    gain_code, e_code);
      chk({tag, "_ready"},   ready,     e_rdy);
      chk({tag, "_bias_en"}, bias_en,   e_ben);
      chk({tag, "_tgt_rdy"}, tgt_rdy,   e_trdy);
      chk({tag, "_oc_cnt"},  oc_cnt,    moc);
      chk({tag, "_fault"},   fault,     0);
      tgt_vld = 1'b0;
    end
    mcode = t;
  endtask

  // One-cycle comparator pulse from HOLD; optionally offer a target in the back-off cycle
  task automatic oc_pulse(input string tag, input bit collide);
    int c;
    c = mcode;
    oc_flag = 1'b1;
    @(negedge clk);
    chk({tag, "_pre_code"}, gain_code, c);
    chk({tag, "_pre_rdy"},  tgt_rdy,   1);
    oc_flag = 1'b0;
    @(negedge clk);
    chk({tag, "_edge_code"}, gain_code, c);
    chk({tag, "_edge_ready"}, ready, 1);
    chk({tag, "_edge_trdy"}, tgt_rdy, 0);
    if (collide) begin
      tgt_vld  = 1'b1;
      tgt_code = 6'd60;
    end
    moc++;
    if (moc == OCMAX) begin
      @(negedge clk);
      chk({tag, "_f_fault"}, fault,     1);
      chk({tag, "_f_code"},  gain_code, 0);
      chk({tag, "_f_ben"},   bias_en,   0);
      chk({tag, "_f_ready"}, ready,     0);
      chk({tag, "_f_cnt"},   oc_cnt,    OCMAX);
      chk({tag, "_f_trdy"},  tgt_rdy,   0);
      tgt_vld = 1'b0;
      mcode   = 0;
    end else begin
      episode(tag, c - 1, c - 1, 1'b0);
    end
  endtask

  initial begin
    int t;
    rstn = 1'b0; en = 1'b0; tgt_code = '0; tgt_vld = 1'b0; oc_flag = 1'b0; clr_fault = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_code", gain_code, 0);
    chk("rst_ben", bias_en, 0);
    chk("rst_ready", ready, 0);
    chk("rst_fault", fault, 0);
    chk("rst_oc", oc_cnt, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("off_trdy", tgt_rdy, 1);
    chk("off_code", gain_code, 0);

    // power-up to 5, retarget to 2, then 3
    en = 1'b1; tgt_vld = 1'b1; tgt_code = 6'd5;
    episode("pwrup", 0, 5, 1'b0);
    tgt_vld = 1'b1; tgt_code = 6'd2;
    episode("retgt", 5, 2, 1'b0);
    tgt_vld = 1'b1; tgt_code = 6'd3;
    episode("to3", 2, 3, 1'b0);

    // shutdown keeps the target; re-enable alone ramps back to it
    en = 1'b0;
    episode("shutdn", 3, 0, 1'b0);
    en = 1'b1;
    episode("reen", 0, 3, 1'b0);

    // equal target in HOLD is a no-op
    tgt_vld = 1'b1; tgt_code = 6'd3;
    episode("same", 3, 3, 1'b1);

    // over-current back-off and fault
    tgt_vld = 1'b1; tgt_code = 6'd5;
    episode("to5", 3, 5, 1'b0);
    oc_pulse("oc1", 1'b0);
    oc_pulse("oc2", 1'b0);
    oc_pulse("oc3", 1'b0);

    tgt_vld = 1'b1; tgt_code = 6'd9; clr_fault = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("clr_en_fault", fault, 1);
      chk("clr_en_trdy", tgt_rdy, 0);
      chk("clr_en_cnt", oc_cnt, OCMAX);
    end
    tgt_vld = 1'b0; en = 1'b0;
    @(negedge clk);
    chk("clr_fault", fault, 0);
    chk("clr_cnt", oc_cnt, 0);
    chk("clr_trdy", tgt_rdy, 1);
    clr_fault = 1'b0; moc = 0;
    en = 1'b1;
    oc_flag = 1'b1;
    @(negedge clk);
    oc_flag = 1'b0;
    repeat (5) @(negedge clk);
    chk("off_oc_cnt", oc_cnt, 0);
    chk("off_tgt_clear_ben", bias_en, 0);
    chk("off_tgt_clear_code", gain_code, 0);

    // collision of a request with the back-off cycle
    tgt_vld = 1'b1; tgt_code = 6'd6;
    episode("to6", 0, 6, 1'b0);
    oc_pulse("coll", 1'b1);

    // randomized retargets from HOLD
    for (int i = 0; i < 10; i++) begin
      if (i == 5) oc_pulse("rnd_oc", 1'b0);
      if (mcode != 0 && $urandom_range(0, 3) == 0) t = mcode;
      else t = $urandom_range(1, 63);
      tgt_vld = 1'b1; tgt_code = 6'(t);
      episode("rnd", mcode, t, (t == mcode) ? 1'b1 : 1'b0);
    end

    // asynchronous reset during an upward ramp
    if (mcode != 0) begin
      en = 1'b0;
      episode("rnd_off", mcode, 0, 1'b0);
    end
    en = 1'b1; tgt_vld = 1'b1; tgt_code = 6'd10;
    for (int m = 1; m <= 13; m++) begin
      @(negedge clk);
      chk("mid_code", gain_code, (m - 1) / STEP);
      tgt_vld = 1'b0;
    end
    #2 rstn = 1'b0;
    #1;
    chk("arst_code", gain_code, 0);
    chk("arst_ben", bias_en, 0);
    chk("arst_ready", ready, 0);
    chk("arst_fault", fault, 0);
    chk("arst_cnt", oc_cnt, 0);
    @(negedge clk);
    rstn = 1'b1; mcode = 0; moc = 0;
    repeat (8) begin
      @(negedge clk);
      chk("post_rst_code", gain_code, 0);
      chk("post_rst_ben", bias_en, 0);
    end
    tgt_vld = 1'b1; tgt_code = 6'd2;
    episode("post_rst", 0, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
